// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction requests into 32-bit words and streams them
// sequentially into instruction memory until it is full.
module instr_encoder #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    kind,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    typedef enum logic {S_LOAD, S_FULL} state_t;

    localparam logic [AW:0] LAST  = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t      state, state_n;
    logic        accept;
    logic        legal;
    logic        wr;
    logic [31:0] word;

    assign accept = in_valid & in_ready;
    assign wr     = accept & legal;

    always_comb begin
        legal = 1'b1;
        word  = '0;
        unique case (kind)
            3'd0: word = {6'b000000, rs, rt, rd, 5'b00000, funct};
            3'd1: word = {6'b100011, rs, rt, imm};
            3'd2: word = {6'b101011, rs, rt, imm};
            3'd3: word = {6'b000100, rs, rt, imm};
            3'd4: word = {6'b001000, rs, rt, imm};
            3'd5: word = {6'b000010, target};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_LOAD;
        else       state <= state_n;
    end

    // Filling the last slot is the only way into the terminal state.
    always_comb begin
        state_n = state;
        if (state == S_LOAD && wr && count == LAST)
            state_n = S_FULL;
    end

    always_comb begin
        in_ready = (state == S_LOAD);
        full     = (count == DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            imem_we <= wr;
            if (wr) begin
                imem_addr <= count[AW-1:0];
                imem_wd   <= word;
                count     <= count + 1'b1;
            end
            if (accept && !legal)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued at drive
// time and popped when imem_we is observed.
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    kind;
    logic [4:0]    rs, rt, rd;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wd;
    } wr_t;

    wr_t sb[$];
    wr_t e;
    int  checks = 0;
    int  errors = 0;

    instr_encoder #(.AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .count(count), .full(full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d wd=%h", imem_addr, imem_wd);
            end else begin
                e = sb.pop_front();
                if (imem_addr !== e.addr || imem_wd !== e.wd) begin
                    errors++;
                    $display("FAIL write got addr=%0d wd=%h exp addr=%0d wd=%h",
                             imem_addr, imem_wd, e.addr, e.wd);
                end
            end
        end
    end

    function automatic logic [31:0] enc(input logic [2:0] k, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] d,
                                        input logic [5:0] f, input logic [15:0] i,
                                        input logic [25:0] tg);
        case (k)
            3'd0:    return {6'h00, s, t, d, 5'h00, f};
            3'd1:    return {6'h23, s, t, i};
            3'd2:    return {6'h2b, s, t, i};
            3'd3:    return {6'h04, s, t, i};
            3'd4:    return {6'h08, s, t, i};
            default: return {6'h02, tg};
        endcase
    endfunction

    task automatic push(input int a, input logic [31:0] w);
        wr_t x;
        x.addr = AW'(a);
        x.wd   = w;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                         input logic [25:0] tg);
        in_valid = 1'b1;
        kind = k; rs = s; rt = t; rd = d;
        funct = f; imm = i; target = tg;
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                        input logic [25:0] tg);
        drive(k, s, t, d, f, i, tg);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // A handshake presented alongside reset must be ignored.
        drive(3'd4, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1234, 26'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, imem_we, full, err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got rdy/we/full/err=%b exp 1000",
                     {in_ready, imem_we, full, err});
        end
        checks++;
        if (count !== '0 || imem_addr !== '0 || imem_wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got cnt=%0d addr=%0d wd=%h exp 0 0 0",
                     count, imem_addr, imem_wd);
        end
        step();
        checks++;
        if (imem_we !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_handshake got we=%b cnt=%0d exp 0 0", imem_we, count);
        end
    endtask

    task automatic test_addi();
        do_reset();
        push(0, 32'h20020005);
        send(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
        checks++;
        if (imem_we !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL addi got we=%b cnt=%0d exp 1 1", imem_we, count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(0, 32'h8C020050);
        push(1, 32'h00641020);
        push(2, 32'h1047000A);
        push(3, 32'h08000011);
        drive(3'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0050, 26'd0);
        step();
        drive(3'd0, 5'd3, 5'd4, 5'd2, 6'h20, 16'h0, 26'd0);
        step();
        drive(3'd3, 5'd2, 5'd7, 5'd0, 6'd0, 16'h000A, 26'd0);
        step();
        drive(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h11);
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got cnt=%0d full=%b rdy=%b exp 4 1 0",
                     count, full, in_ready);
        end
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got pending=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_illegal();
        do_reset();
        push(0, 32'h20020005);
        send(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
        send(3'd6, 5'd1, 5'd1, 5'd1, 6'd1, 16'hFFFF, 26'h3FFFFFF);
        checks++;
        if (imem_we !== 1'b0 || err !== 1'b1 || count !== 3'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal got we=%b err=%b cnt=%0d rdy=%b exp 0 1 1 1",
                     imem_we, err, count, in_ready);
        end
        push(1, 32'h8C020050);
        send(3'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0050, 26'd0);
        step();
        checks++;
        if (err !== 1'b1 || count !== 3'd2) begin
            errors++;
            $display("FAIL illegal_hold got err=%b cnt=%0d exp 1 2", err, count);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(i, 32'h20200000 | (32'(i) << 16) | 32'(i));
            drive(3'd4, 5'd1, 5'(i), 5'd0, 6'd0, 16'(i), 26'd0);
            step();
        end
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL full_flag got full=%b rdy=%b cnt=%0d exp 1 0 4",
                     full, in_ready, count);
        end
        drive(3'd4, 5'd1, 5'd9, 5'd0, 6'd0, 16'h0009, 26'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count !== 3'd4 || full !== 1'b1 || imem_we !== 1'b0) begin
                errors++;
                $display("FAIL full_stuck got cnt=%0d full=%b we=%b exp 4 1 0",
                         count, full, imem_we);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_cancel();
        do_reset();
        send(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0);
        push(0, 32'h20020005);
        send(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (imem_we !== 1'b0 || count !== '0 || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cancel got we=%b cnt=%0d err=%b rdy=%b exp 0 0 0 1",
                     imem_we, count, err, in_ready);
        end
        push(0, 32'h8C020050);
        send(3'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0050, 26'd0);
        checks++;
        if (imem_addr !== '0 || count !== 3'd1) begin
            errors++;
            $display("FAIL reset_restart got addr=%0d cnt=%0d exp 0 1", imem_addr, count);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            kind = 3'(i % 6);
            imm  = 16'(i * 7);
            step();
            checks++;
            if (imem_we !== 1'b0 || count !== 3'd1 || imem_addr !== '0
                || imem_wd !== 32'h8C020050) begin
                errors++;
                $display("FAIL idle got we=%b cnt=%0d addr=%0d wd=%h exp 0 1 0 8c020050",
                         imem_we, count, imem_addr, imem_wd);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  k;
        logic [4:0]  s, t, d;
        logic [5:0]  f;
        logic [15:0] i16;
        logic [25:0] tg;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            k   = 3'($urandom_range(0, 5));
            s   = 5'($urandom);
            t   = 5'($urandom);
            d   = 5'($urandom);
            f   = 6'($urandom);
            i16 = 16'($urandom);
            tg  = 26'($urandom);
            push(i, enc(k, s, t, d, f, i16, tg));
            drive(k, s, t, d, f, i16, tg);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (sb.size() != 0 || count !== 3'd4) begin
            errors++;
            $display("FAIL random got pending=%0d cnt=%0d exp 0 4", sb.size(), count);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0;
        funct = '0; imm = '0; target = '0;
        step();
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_full();
        test_reset_cancel();
        test_idle();
        test_random();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain got pending=%0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: AW, default 6, instruction-memory address width (depth 2**AW words).
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  encode request present.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: kind  input  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6-7 illegal.
REQ-007 Port: rs, rt, rd  input  5 each  register fields.
REQ-008 Port: funct  input  6  R-type function field.
REQ-009 Port: imm  input  16  immediate / branch offset, passed through unmodified.
REQ-010 Port: target  input  26  jump target field.
REQ-011 Port: imem_we  output  1  instruction-memory write strobe.
REQ-012 Port: imem_addr  output  AW  word write address.
REQ-013 Port: imem_wd  output  32  encoded instruction word.
REQ-014 Port: count  output  AW+1  number of words written since reset.
REQ-015 Port: full  output  1  memory full; no further requests accepted.
REQ-016 Port: err  output  1  sticky flag: an illegal kind was accepted.

Function
REQ-017 Handshake: request accepted on a rising edge where in_valid=1 and in_ready=1; request inputs are ignored when in_valid=0.
REQ-018 in_ready SHALL equal (state==LOAD); throughput SHALL be one request per cycle.
REQ-019 FSM states: LOAD (accepting), FULL (terminal until reset).
REQ-020 LOAD->FULL on the edge that accepts a legal request while count==2**AW-1.
REQ-021 FULL SHALL have no exit other than reset.
REQ-022 Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
REQ-023 RTYPE word: {000000, rs, rt, rd, 00000, funct}.
REQ-024 LW, SW, BEQ and ADDI word: {op, rs, rt, imm}.
REQ-025 J word: {000010, target}.
REQ-026 Fields not used by the selected kind are ignored.
REQ-027 Output latency: one cycle; imem_we/imem_addr/imem_wd SHALL be registered and valid in the cycle after acceptance.
REQ-028 imem_we SHALL pulse high for exactly one cycle per accepted legal request and SHALL be 0 otherwise.
REQ-029 Write pointer starts at 0 and increments by 1 per legal write; imem_addr SHALL equal the pointer value at acceptance.
REQ-030 count increments in the same cycle imem_we asserts; full=1 when count==2**AW.
REQ-031 No write SHALL occur beyond address 2**AW-1, and the pointer SHALL NOT wrap.
REQ-032 Illegal kind, when accepted: no write, pointer and count unchanged, err set to 1 and held, FSM stays in LOAD.
REQ-033 imem_addr and imem_wd hold their last values when imem_we=0.

Reset
REQ-034 When reset=1 at a rising edge, the next cycle SHALL show: state=LOAD, in_ready=1, imem_we=0, imem_addr=0, imem_wd=0, count=0, full=0, err=0.
REQ-035 Reset overrides a simultaneous handshake; a write pending from the previous cycle SHALL be cancelled (imem_we=0 after reset).

Verification
REQ-036 ADDI rs=0 rt=2 imm=0x0005 -> next cycle imem_we=1, imem_addr=0, imem_wd=0x20020005, count=1.
REQ-037 Back-to-back, one per cycle: LW rs=0 rt=2 imm=0x0050; RTYPE rs=3 rt=4 rd=2 funct=0x20; BEQ rs=2 rt=7 imm=0x000A; J target=0x11 -> consecutive writes of 0x8C020050, 0x00641020, 0x1047000A, 0x08000011 at addresses 0-3.
REQ-038 kind=6 between two legal requests -> no write for kind=6, err=1 and held, the next legal write goes to the following address, count unchanged by the illegal request.
REQ-039 With AW=2, issue 5 legal requests with in_valid held high -> 4 writes (addresses 0-3), full=1 and in_ready=0 after the 4th acceptance, 5th request never accepted.
REQ-040 reset asserted in the cycle after an acceptance -> imem_we=0 in that cycle's successor, count=0, err=0; the next request writes address 0.
REQ-041 in_valid=0 for 10 cycles -> imem_we stays 0, and count and outputs are unchanged.
